// File: rtl/muxn_lut_reg_frame_config_pkg.sv
// rtl/muxn_lut_reg_frame_config_pkg.sv - shared config-bit layout and control struct for the mux tree BEL
package muxn_lut_reg_frame_config_pkg;

    // reg_en bits start at the bottom of ConfigBits: one per M tap, then one for M_HI
    localparam int CFG_REG_EN_LSB = 0;

    // Global control bits decoded from the frame config
    typedef struct packed {
        logic pipe_en;
        logic init;
    } cfg_ctrl_t;

    // pipe_en sits directly above the SEL_BITS+1 reg_en bits
    function automatic int cfg_pipe_en_idx(input int sel_bits);
        return sel_bits + 1;
    endfunction

    // init is the topmost config bit
    function automatic int cfg_init_idx(input int sel_bits);
        return sel_bits + 2;
    endfunction

endpackage

// File: rtl/cus_mux21.sv
// rtl/cus_mux21.sv - 2:1 fabric mux cell used for tree nodes and bypass selection
module cus_mux21 (
    input  logic a0,
    input  logic a1,
    input  logic s,
    output logic x
);
    assign x = s ? a1 : a0;
endmodule

// File: rtl/muxn_lut_reg_frame_config_tree_level.sv
// rtl/muxn_lut_reg_frame_config_tree_level.sv - one level of the binary mux tree: W inputs reduced to W/2
module muxn_lut_reg_frame_config_tree_level #(
    parameter int W = 2
) (
    input  logic [W-1:0]   data,
    input  logic           sel,
    output logic [W/2-1:0] reduced
);
    // Each output j picks between adjacent inputs 2j and 2j+1, so element 0 is always the lowest subtree
    for (genvar j = 0; j < W / 2; j++) begin : g_node
        cus_mux21 u_mux (
            .a0 (data[2*j]),
            .a1 (data[2*j+1]),
            .s  (sel),
            .x  (reduced[j])
        );
    end
endmodule

// File: rtl/muxn_lut_reg_frame_config.sv
// rtl/muxn_lut_reg_frame_config.sv - frame-configured 2**SEL_BITS:1 mux tree BEL with optional pipeline and output flops
(* FABulous, BelMap, reg_en0=0, reg_en1=1, reg_en2=2, reg_en_hi=3, pipe_en=4, init=5 *)
module muxn_lut_reg_frame_config
    import muxn_lut_reg_frame_config_pkg::*;
#(
    parameter int SEL_BITS     = 3,
    parameter int PIPE_LEVEL   = 2,
    parameter int NoConfigBits = SEL_BITS + 3
) (
    input  logic                    UserCLK,
    input  logic                    SR,
    input  logic                    CE,
    input  logic [2**SEL_BITS-1:0]  I,
    input  logic [SEL_BITS-1:0]     S,
    output logic [SEL_BITS-1:0]     M,
    output logic                    M_HI,
    input  logic [NoConfigBits-1:0] ConfigBits
);
    localparam int N           = 2 ** SEL_BITS;
    localparam int NH          = N / 2;
    localparam int PIPE_W      = N >> PIPE_LEVEL;
    localparam int PIPE_HW     = PIPE_W / 2;
    localparam int SW          = SEL_BITS - PIPE_LEVEL;
    localparam int CFG_PIPE_EN = cfg_pipe_en_idx(SEL_BITS);
    localparam int CFG_INIT    = cfg_init_idx(SEL_BITS);

    logic [SEL_BITS:0]   reg_en;
    cfg_ctrl_t           ctrl;

    // Stage-1 pipeline state: partials after level PIPE_LEVEL-1, low taps, upper select bits
    logic [PIPE_W-1:0]   st1_lo;
    logic [PIPE_HW-1:0]  st1_hi;
    logic [PIPE_LEVEL-1:0] st1_tap;
    logic [SW-1:0]       st1_s;

    logic [PIPE_W-1:0]   mid_lo;
    logic [PIPE_HW-1:0]  mid_hi;
    logic [SEL_BITS-1:0] lvl_sel;
    logic [SEL_BITS-1:0] tap_comb;
    logic [SEL_BITS:0]   pre;
    logic [SEL_BITS:0]   out_q;
    logic [SEL_BITS:0]   out_v;

    assign reg_en = ConfigBits[CFG_REG_EN_LSB +: SEL_BITS+1];
    assign ctrl   = '{pipe_en: ConfigBits[CFG_PIPE_EN], init: ConfigBits[CFG_INIT]};

    // Levels past the pipeline point switch to the registered select so data and select stay aligned
    for (genvar k = 0; k < SEL_BITS; k++) begin : g_sel
        if (k < PIPE_LEVEL) begin : g_live
            assign lvl_sel[k] = S[k];
        end else begin : g_muxed
            cus_mux21 u_sel (.a0(S[k]), .a1(st1_s[k-PIPE_LEVEL]), .s(ctrl.pipe_en), .x(lvl_sel[k]));
        end
    end

    // Lower tree over all N inputs; level PIPE_LEVEL takes stage-1 partials when pipelined
    for (genvar k = 0; k < SEL_BITS; k++) begin : g_lo
        localparam int WI = N >> k;
        logic [WI-1:0]   data;
        logic [WI/2-1:0] q;
        if (k == 0) begin : g_leaf
            assign data = I;
        end else if (k == PIPE_LEVEL) begin : g_pipe
            for (genvar b = 0; b < WI; b++) begin : g_byp
                cus_mux21 u_byp (.a0(g_lo[k-1].q[b]), .a1(st1_lo[b]), .s(ctrl.pipe_en), .x(data[b]));
            end
        end else begin : g_chain
            assign data = g_lo[k-1].q;
        end
        muxn_lut_reg_frame_config_tree_level #(.W(WI)) u_lvl (
            .data    (data),
            .sel     (lvl_sel[k]),
            .reduced (q)
        );
        assign tap_comb[k] = q[0];
    end

    // Upper-half tree over I[N-1:N/2], sharing the per-level selects with the lower tree
    for (genvar k = 0; k < SEL_BITS - 1; k++) begin : g_hi
        localparam int WI = NH >> k;
        logic [WI-1:0]   data;
        logic [WI/2-1:0] q;
        if (k == 0) begin : g_leaf
            assign data = I[N-1:NH];
        end else if (k == PIPE_LEVEL) begin : g_pipe
            for (genvar b = 0; b < WI; b++) begin : g_byp
                cus_mux21 u_byp (.a0(g_hi[k-1].q[b]), .a1(st1_hi[b]), .s(ctrl.pipe_en), .x(data[b]));
            end
        end else begin : g_chain
            assign data = g_hi[k-1].q;
        end
        muxn_lut_reg_frame_config_tree_level #(.W(WI)) u_lvl (
            .data    (data),
            .sel     (lvl_sel[k]),
            .reduced (q)
        );
    end

    assign mid_lo = g_lo[PIPE_LEVEL-1].q;
    assign mid_hi = g_hi[PIPE_LEVEL-1].q;

    // Taps finished before the pipeline point come straight from stage-1 when pipelined
    for (genvar k = 0; k < SEL_BITS; k++) begin : g_pre
        if (k < PIPE_LEVEL) begin : g_early
            cus_mux21 u_tap (.a0(tap_comb[k]), .a1(st1_tap[k]), .s(ctrl.pipe_en), .x(pre[k]));
        end else begin : g_late
            assign pre[k] = tap_comb[k];
        end
    end

    // When the pipeline point is the last upper level, stage-1 already holds the final M_HI value
    if (PIPE_LEVEL == SEL_BITS - 1) begin : g_hi_pre_byp
        cus_mux21 u_hi (.a0(g_hi[SEL_BITS-2].q[0]), .a1(st1_hi[0]), .s(ctrl.pipe_en), .x(pre[SEL_BITS]));
    end else begin : g_hi_pre_direct
        assign pre[SEL_BITS] = g_hi[SEL_BITS-2].q[0];
    end

    // Stage-1 bank: SR fills everything with init (discarding in-flight data), else loads on CE
    always_ff @(posedge UserCLK) begin
        if (SR) begin
            st1_lo  <= {PIPE_W{ctrl.init}};
            st1_hi  <= {PIPE_HW{ctrl.init}};
            st1_tap <= {PIPE_LEVEL{ctrl.init}};
            st1_s   <= {SW{ctrl.init}};
        end else if (CE) begin
            st1_lo  <= mid_lo;
            st1_hi  <= mid_hi;
            st1_tap <= tap_comb[PIPE_LEVEL-1:0];
            st1_s   <= S[SEL_BITS-1:PIPE_LEVEL];
        end
    end

    // Output flops: one per tap plus M_HI, reset to init, loaded from the pre-register value on CE
    always_ff @(posedge UserCLK) begin
        if (SR) begin
            out_q <= {(SEL_BITS+1){ctrl.init}};
        end else if (CE) begin
            out_q <= pre;
        end
    end

    // reg_en picks the flop or the unregistered value per output
    for (genvar k = 0; k <= SEL_BITS; k++) begin : g_out
        cus_mux21 u_out (.a0(pre[k]), .a1(out_q[k]), .s(reg_en[k]), .x(out_v[k]));
    end

    assign M    = out_v[SEL_BITS-1:0];
    assign M_HI = out_v[SEL_BITS];

endmodule

// File: tb/tb_muxn_lut_reg_frame_config.sv
// tb/tb_muxn_lut_reg_frame_config.sv - self-checking bench for the mux tree BEL against a behavioural model
module tb_muxn_lut_reg_frame_config;

    logic       clk = 1'b0;
    logic       SR;
    logic       CE;
    logic [7:0] I;
    logic [2:0] S;
    logic [2:0] M;
    logic       M_HI;
    logic [5:0] cfg;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] m_st1;
    logic [3:0] m_q;
    logic [3:0] last_obs;
    logic [7:0] pat;

    muxn_lut_reg_frame_config #(
        .SEL_BITS     (3),
        .PIPE_LEVEL   (2),
        .NoConfigBits (6)
    ) dut (
        .UserCLK    (clk),
        .SR         (SR),
        .CE         (CE),
        .I          (I),
        .S          (S),
        .M          (M),
        .M_HI       (M_HI),
        .ConfigBits (cfg)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] make_cfg(input logic [3:0] reg_en, input logic pipe, input logic init);
        return {init, pipe, reg_en};
    endfunction

    // Ideal mux outputs {M_HI, M[2], M[1], M[0]} straight from the indexing rules
    function automatic logic [3:0] ideal(input logic [7:0] i, input logic [2:0] s);
        logic [3:0] r;
        r[0] = i[{2'b00, s[0]}];
        r[1] = i[{1'b0, s[1:0]}];
        r[2] = i[s];
        r[3] = i[3'd4 + {1'b0, s[1:0]}];
        return r;
    endfunction

    function automatic logic [3:0] model_pre(input logic [7:0] i, input logic [2:0] s);
        return cfg[4] ? m_st1 : ideal(i, s);
    endfunction

    function automatic logic [3:0] model_out(input logic [7:0] i, input logic [2:0] s);
        return (cfg[3:0] & m_q) | (~cfg[3:0] & model_pre(i, s));
    endfunction

    task automatic model_clock(input logic sr, input logic ce, input logic [7:0] i, input logic [2:0] s);
        logic [3:0] p;
        p = model_pre(i, s);
        if (sr) begin
            m_q   = {4{cfg[5]}};
            m_st1 = {4{cfg[5]}};
        end else if (ce) begin
            m_q   = p;
            m_st1 = ideal(i, s);
        end
    endtask

    // Entered just after a falling edge: drive, check settled outputs, clock once, advance the model
    task automatic cycle(input logic sr, input logic ce, input logic [7:0] i, input logic [2:0] s, input string tag);
        logic [3:0] expv;
        SR = sr;
        CE = ce;
        I  = i;
        S  = s;
        #1;
        expv     = model_out(i, s);
        last_obs = {M_HI, M};
        compared++;
        assert (last_obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, last_obs, expv);
        end
        @(posedge clk);
        model_clock(sr, ce, i, s);
        @(negedge clk);
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    initial begin
        m_st1 = 4'h0;
        m_q   = 4'h0;
        cfg   = make_cfg(4'hF, 1'b1, 1'b0);
        SR = 1'b1; CE = 1'b0; I = 8'h00; S = 3'd0;
        @(posedge clk);
        model_clock(1'b1, 1'b0, 8'h00, 3'd0);
        @(negedge clk);

        // Reset state with everything registered and init=0
        cycle(1'b0, 1'b0, 8'hFF, 3'd7, "reset_state");
        check4("reset_zero", last_obs, 4'h0);

        // Combinational sweep
        cfg = make_cfg(4'h0, 1'b0, 1'b0);
        pat = 8'b1010_0110;
        for (int v = 0; v < 8; v++) begin
            cycle(1'b0, 1'b1, pat, 3'(v), "comb_sweep");
            check4("comb_m2", {3'b000, last_obs[2]}, {3'b000, pat[v]});
        end

        // Registered outputs, one cycle latency
        cfg = make_cfg(4'hF, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h01, 3'd0, "reg_s0");
        cycle(1'b0, 1'b1, 8'h01, 3'd1, "reg_s1");
        check4("reg_m2_hi", {3'b000, last_obs[2]}, 4'd1);
        cycle(1'b0, 1'b1, 8'h01, 3'd1, "reg_s1b");
        check4("reg_m2_lo", {3'b000, last_obs[2]}, 4'd0);

        // Pipeline only: pulse one cycle later
        cfg = make_cfg(4'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipe_pre");
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipe_pre");
        cycle(1'b0, 1'b1, 8'h80, 3'd7, "pipe_s7");
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipe_a");
        check4("pipe_lat1_hi", {3'b000, last_obs[2]}, 4'd1);
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipe_b");
        check4("pipe_lat1_lo", {3'b000, last_obs[2]}, 4'd0);

        // Pipeline plus output flops: pulse two cycles later
        cfg = make_cfg(4'hF, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipereg_pre");
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipereg_pre");
        cycle(1'b0, 1'b1, 8'h80, 3'd7, "pipereg_s7");
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipereg_a");
        check4("pipereg_lat1", {3'b000, last_obs[2]}, 4'd0);
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipereg_b");
        check4("pipereg_lat2", {3'b000, last_obs[2]}, 4'd1);
        cycle(1'b0, 1'b1, 8'h80, 3'd0, "pipereg_c");
        check4("pipereg_after", {3'b000, last_obs[2]}, 4'd0);

        // Select alignment across the pipeline point
        cfg = make_cfg(4'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 8'hF0, 3'd3, "align_s3");
        cycle(1'b0, 1'b1, 8'hF0, 3'd3, "align_s3");
        cycle(1'b0, 1'b1, 8'hF0, 3'd4, "align_s4a");
        check4("align_old", {3'b000, last_obs[2]}, 4'd0);
        cycle(1'b0, 1'b1, 8'hF0, 3'd4, "align_s4b");
        check4("align_new", {3'b000, last_obs[2]}, 4'd1);

        // Reset wins over CE=0, then hold, then recovery
        cfg = make_cfg(4'hF, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 3'd0, "sr_ce0");
        cycle(1'b0, 1'b0, 8'hFF, 3'd5, "hold_a");
        check4("sr_init", last_obs, 4'hF);
        cycle(1'b0, 1'b0, 8'h00, 3'd2, "hold_b");
        check4("hold_init", last_obs, 4'hF);
        cycle(1'b0, 1'b1, 8'h00, 3'd0, "ce_a");
        check4("ce_lat0", last_obs, 4'hF);
        cycle(1'b0, 1'b1, 8'h00, 3'd0, "ce_b");
        check4("ce_lat1", last_obs, 4'hF);
        cycle(1'b0, 1'b1, 8'h00, 3'd0, "ce_c");
        check4("ce_lat2", last_obs, 4'h0);

        // Mid-operation reset flushes stage-1
        cfg = make_cfg(4'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 8'hFF, 3'd0, "mid_a");
        cycle(1'b0, 1'b1, 8'hFF, 3'd0, "mid_b");
        cycle(1'b0, 1'b1, 8'hFF, 3'd0, "mid_c");
        check4("mid_stream", {3'b000, last_obs[2]}, 4'd1);
        cycle(1'b1, 1'b1, 8'hFF, 3'd0, "mid_sr");
        cycle(1'b0, 1'b1, 8'hFF, 3'd0, "mid_flush");
        check4("mid_flushed", {3'b000, last_obs[2]}, 4'd0);
        cycle(1'b0, 1'b1, 8'hFF, 3'd0, "mid_back");
        check4("mid_recover", {3'b000, last_obs[2]}, 4'd1);

        // Randomized traffic with occasional config, SR and CE changes
        for (int n = 0; n < 400; n++) begin
            if (n % 25 == 0) cfg = 6'($urandom);
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 3'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
